// File: rtl/pusch_pkg.sv
// Shared definitions for the PUSCH symbol scheduler: FSM encoding, grid limits and
// the allocation legality rule used by the CHECK state.
package pusch_pkg;

  localparam int               SYM_W     = 4;
  localparam logic [11:0]      TOTAL_SC  = 12'd1200;
  localparam logic [6:0]       MAX_RB    = 7'd100;
  localparam logic [11:0]      SC_PER_RB = 12'd12;
  localparam logic [SYM_W-1:0] LAST_SYM  = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  // The allocation extent is formed in 12 bits so N_sc + 12*N_rb can never wrap.
  function automatic logic cfg_legal(input logic [10:0]      n_sc,
                                     input logic [6:0]       n_rb,
                                     input logic [SYM_W-1:0] sym_start,
                                     input logic [SYM_W-1:0] sym_end);
    logic [11:0] extent;
    extent = {1'b0, n_sc} + 12'(n_rb) * SC_PER_RB;
    return (n_rb != 7'd0) && (n_rb <= MAX_RB) && (sym_start <= sym_end) &&
           (sym_end <= LAST_SYM) && (extent <= TOTAL_SC);
  endfunction

endpackage

// File: rtl/pusch_symbol_scheduler_if.sv
// Mapper/consumer-facing signals of the PUSCH symbol scheduler.
interface pusch_symbol_scheduler_if;
  import pusch_pkg::*;

  // dmrs_req/fft_req are one-cycle request strobes answered by a one-cycle Sym_Done;
  // buf_full[i] is a level "valid" to the consumer, buf_release[i] its one-cycle acknowledge.
  logic                 Sym_Done;
  logic [1:0]           buf_release;
  logic                 dmrs_req;
  logic                 fft_req;
  logic [SYM_W-1:0]     sym_idx;
  logic                 wr_buf;
  logic [1:0]           buf_full;
  logic [2*SYM_W-1:0]   full_sym;

  modport master (
    input  Sym_Done, buf_release,
    output dmrs_req, fft_req, sym_idx, wr_buf, buf_full, full_sym
  );

  modport slave (
    output Sym_Done, buf_release,
    input  dmrs_req, fft_req, sym_idx, wr_buf, buf_full, full_sym
  );

endinterface

// File: rtl/pingpong_owner.sv
// Two-entry ping-pong grid buffer tracker: per-buffer full flag and the symbol it holds.
module pingpong_owner
  import pusch_pkg::*;
(
  input  logic                 CLK_RE,
  input  logic                 RST_RE,
  input  logic                 i_set,
  input  logic                 i_set_idx,
  input  logic [SYM_W-1:0]     i_sym,
  input  logic [1:0]           i_release,
  input  logic                 i_clear,
  output logic [1:0]           o_buf_full,
  output logic [1:0]           o_buf_full_nxt,
  output logic [2*SYM_W-1:0]   o_full_sym
);

  logic [1:0]       r_full;
  logic [SYM_W-1:0] r_sym0;
  logic [SYM_W-1:0] r_sym1;
  logic [1:0]       w_full_nxt;

  // Set beats a same-cycle release of the same buffer; clear beats everything.
  always_comb begin
    w_full_nxt = r_full & ~i_release;
    if (i_set) w_full_nxt[i_set_idx] = 1'b1;
    if (i_clear) w_full_nxt = 2'b00;
  end

  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      r_full <= 2'b00;
      r_sym0 <= '0;
      r_sym1 <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (i_clear) begin
        r_sym0 <= '0;
        r_sym1 <= '0;
      end else if (i_set) begin
        if (i_set_idx) r_sym1 <= i_sym;
        else           r_sym0 <= i_sym;
      end
    end
  end

  assign o_buf_full     = r_full;
  assign o_buf_full_nxt = w_full_nxt;
  assign o_full_sym     = {r_sym1, r_sym0};

endmodule

// File: rtl/pusch_symbol_scheduler.sv
// Slot-level sequencer for the PUSCH RE mapper: validates the allocation, then walks
// symbols Sym_Start..Sym_End (DMRS first, FFT after) through a ping-pong grid buffer.
module pusch_symbol_scheduler
  import pusch_pkg::*;
#(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                    CLK_RE,
  input  logic                    RST_RE,
  input  logic                    start,
  input  logic                    abort,
  input  logic [10:0]             cfg_N_sc,
  input  logic [6:0]              cfg_N_rb,
  input  logic [SYM_W-1:0]        cfg_Sym_Start,
  input  logic [SYM_W-1:0]        cfg_Sym_End,
  output logic                    busy,
  output logic                    slot_done,
  output logic                    cfg_err,
  output logic                    timeout_err,
  output state_t                  dbg_state,
  pusch_symbol_scheduler_if.master bus
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               r_state;
  logic [10:0]          r_n_sc;
  logic [6:0]           r_n_rb;
  logic [SYM_W-1:0]     r_sym_start;
  logic [SYM_W-1:0]     r_sym_end;
  logic [SYM_W-1:0]     r_sym_idx;
  logic                 r_wr_buf;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_dmrs_req;
  logic                 r_fft_req;
  logic                 r_slot_done;
  logic                 r_cfg_err;
  logic                 r_timeout_err;

  logic                 w_set;
  logic                 w_timeout;
  logic                 w_clear;
  logic [1:0]           w_buf_full;
  logic [1:0]           w_buf_full_nxt;
  logic [2*SYM_W-1:0]   w_full_sym;

  assign w_set     = (r_state == ST_WAIT_DONE) && bus.Sym_Done && !abort;
  assign w_timeout = (r_state == ST_WAIT_DONE) && !bus.Sym_Done && (r_wd == WD_LAST);
  assign w_clear   = abort || w_timeout;

  pingpong_owner u_pingpong (
    .CLK_RE         (CLK_RE),
    .RST_RE         (RST_RE),
    .i_set          (w_set),
    .i_set_idx      (r_wr_buf),
    .i_sym          (r_sym_idx),
    .i_release      (bus.buf_release),
    .i_clear        (w_clear),
    .o_buf_full     (w_buf_full),
    .o_buf_full_nxt (w_buf_full_nxt),
    .o_full_sym     (w_full_sym)
  );

  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      r_state       <= ST_IDLE;
      r_n_sc        <= '0;
      r_n_rb        <= '0;
      r_sym_start   <= '0;
      r_sym_end     <= '0;
      r_sym_idx     <= '0;
      r_wr_buf      <= 1'b0;
      r_wd          <= '0;
      r_dmrs_req    <= 1'b0;
      r_fft_req     <= 1'b0;
      r_slot_done   <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dmrs_req    <= 1'b0;
      r_fft_req     <= 1'b0;
      r_slot_done   <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      if (abort) begin
        r_state   <= ST_IDLE;
        r_sym_idx <= '0;
        r_wr_buf  <= 1'b0;
        r_wd      <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_n_sc      <= cfg_N_sc;
              r_n_rb      <= cfg_N_rb;
              r_sym_start <= cfg_Sym_Start;
              r_sym_end   <= cfg_Sym_End;
              r_state     <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (cfg_legal(r_n_sc, r_n_rb, r_sym_start, r_sym_end)) begin
              r_sym_idx <= r_sym_start;
              r_wr_buf  <= 1'b0;
              r_state   <= ST_REQ;
            end else begin
              r_cfg_err <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
          ST_REQ: begin
            // Hold the request until the consumer has drained the target buffer.
            if (!w_buf_full[r_wr_buf]) begin
              if (r_sym_idx == r_sym_start) r_dmrs_req <= 1'b1;
              else                          r_fft_req  <= 1'b1;
              r_wd    <= '0;
              r_state <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
            if (bus.Sym_Done) begin
              r_wr_buf <= ~r_wr_buf;
              if (r_sym_idx == r_sym_end) begin
                r_state <= ST_DRAIN;
              end else begin
                r_sym_idx <= r_sym_idx + 4'd1;
                r_state   <= ST_REQ;
              end
            end else if (w_timeout) begin
              r_timeout_err <= 1'b1;
              r_sym_idx     <= '0;
              r_wr_buf      <= 1'b0;
              r_state       <= ST_IDLE;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
          ST_DRAIN: begin
            // Looking at the next-cycle flags lets slot_done follow the last release by one cycle.
            if (w_buf_full_nxt == 2'b00) begin
              r_slot_done <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign slot_done    = r_slot_done;
  assign cfg_err      = r_cfg_err;
  assign timeout_err  = r_timeout_err;
  assign dbg_state    = r_state;

  assign bus.dmrs_req = r_dmrs_req;
  assign bus.fft_req  = r_fft_req;
  assign bus.sym_idx  = r_sym_idx;
  assign bus.wr_buf   = r_wr_buf;
  assign bus.buf_full = w_buf_full;
  assign bus.full_sym = w_full_sym;

endmodule
